pes_moisture_conditioner: RTL and testbench

Front-end conditioning stage that turns raw soil-moisture ADC samples into the clean, single-bit `moisture_sensor` request consumed by `pes_plant_watering`. It block-averages 2^AVG_LOG2 samples and applies a two-threshold hysteresis so the pump controller never sees chatter near the switching point. An optional watchdog forces a safe "not dry" output when samples stop arriving.

---
 rtl/pes_moisture_conditioner.sv | 142 ++++++++++++++
 tb/tb_pes_moisture_conditioner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pes_moisture_conditioner.sv
// ============================================================================
// Module   : pes_moisture_conditioner
// Purpose  : Block-averages ADC moisture samples and applies two-threshold
//            hysteresis to produce a chatter-free "soil dry" request.
//            Optional idle watchdog enabled by defining MOIST_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pes_moisture_conditioner #(
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 2,
  parameter int DRY_TH   = 300,
  parameter int WET_TH   = 500,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              moisture_sensor,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  output logic              sensor_fault
);

  localparam int c_ACC_W = DATA_W + AVG_LOG2;
  localparam logic [DATA_W-1:0] c_DRY_TH = DATA_W'(DRY_TH);
  localparam logic [DATA_W-1:0] c_WET_TH = DATA_W'(WET_TH);

  typedef enum logic [0:0] {
    ST_WET = 1'b0,
    ST_DRY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_ACC_W-1:0]  r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [c_ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0]   w_avg;
  logic                w_last;
  logic                w_fault_hit;

  assign w_sum  = r_acc + c_ACC_W'(adc_data);
  assign w_avg  = w_sum[c_ACC_W-1:AVG_LOG2];
  assign w_last = adc_valid && (r_cnt == {AVG_LOG2{1'b1}});

  // Sample accumulation; a watchdog fault throws away the partial block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fault_hit) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (adc_valid) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg_data  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= w_last;
      if (w_last) begin
        avg_data <= w_avg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_WET;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_fault_hit) begin
      w_state_next = ST_WET;
    end else if (w_last) begin
      case (r_state)
        ST_WET:  if (w_avg < c_DRY_TH)  w_state_next = ST_DRY;
        ST_DRY:  if (w_avg >= c_WET_TH) w_state_next = ST_WET;
        default: w_state_next = ST_WET;
      endcase
    end
  end

  assign moisture_sensor = (r_state == ST_DRY);

`ifdef MOIST_WATCHDOG_EN
  localparam int c_IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [c_IDLE_W-1:0] c_TIMEOUT    = c_IDLE_W'(TIMEOUT);
  localparam logic [c_IDLE_W-1:0] c_TIMEOUT_M1 = c_IDLE_W'(TIMEOUT - 1);

  logic [c_IDLE_W-1:0] r_idle;
  logic                r_fault;

  // Fault fires only on the edge the idle count reaches TIMEOUT.
  assign w_fault_hit = !adc_valid && (r_idle == c_TIMEOUT_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle  <= '0;
      r_fault <= 1'b0;
    end else if (adc_valid) begin
      r_idle  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_idle != c_TIMEOUT) begin
        r_idle <= r_idle + 1'b1;
      end
      if (w_fault_hit) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign sensor_fault = r_fault;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT;
  assign w_fault_hit      = 1'b0;
  assign sensor_fault     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pes_moisture_conditioner.sv
// ============================================================================
// Module   : tb_pes_moisture_conditioner
// Purpose  : Scoreboard bench for pes_moisture_conditioner (TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pes_moisture_conditioner;

  localparam int DATA_W  = 10;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              moisture_sensor;
  logic [DATA_W-1:0] avg_data;
  logic              avg_valid;
  logic              sensor_fault;

  pes_moisture_conditioner #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(2),
    .DRY_TH  (300),
    .WET_TH  (500),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .moisture_sensor(moisture_sensor),
    .avg_data       (avg_data),
    .avg_valid      (avg_valid),
    .sensor_fault   (sensor_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected {moisture_sensor, avg_data} per completed block
  logic [DATA_W:0] exp_q[$];

  int m_acc;
  int m_cnt;
  int m_idle;
  bit m_dry;

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_idle = 0;
    m_dry  = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      adc_valid = 1'b0;
      @(posedge clk);
      if (m_idle < TIMEOUT) begin
        m_idle++;
`ifdef MOIST_WATCHDOG_EN
        if (m_idle == TIMEOUT) begin
          m_acc = 0;
          m_cnt = 0;
          m_dry = 1'b0;
        end
`endif
      end
      #1;
      total++;
      if (avg_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_avg_valid: got %b want 0 at %0t", avg_valid, $time);
      end
    end
  endtask

  task automatic send(input int d);
    int avg;
    logic [DATA_W:0] e;
    adc_valid = 1'b1;
    adc_data  = DATA_W'(d);
    m_idle    = 0;
    m_acc     = m_acc + d;
    m_cnt++;
    if (m_cnt == N) begin
      avg = m_acc / N;
      if (!m_dry && avg < 300) m_dry = 1'b1;
      else if (m_dry && avg >= 500) m_dry = 1'b0;
      exp_q.push_back({m_dry, DATA_W'(avg)});
      m_acc = 0;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    adc_valid = 1'b0;
    total++;
    if (avg_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: avg_valid=1 avg=%0d, no block expected", avg_data);
      end else begin
        e = exp_q.pop_front();
        total++;
        if ({moisture_sensor, avg_data} !== e) begin
          bad++;
          $display("FAIL sb_block: got sensor=%b avg=%0d want sensor=%b avg=%0d",
                   moisture_sensor, avg_data, e[DATA_W], e[DATA_W-1:0]);
        end
      end
    end else if (exp_q.size() != 0) begin
      bad++;
      e = exp_q.pop_front();
      $display("FAIL sb_missing: avg_valid=%b want 1 (avg %0d)", avg_valid, e[DATA_W-1:0]);
    end
  endtask

  task automatic block(input int v);
    repeat (N) send(v);
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      adc_valid = ~adc_valid;
      adc_data  = DATA_W'(777);
    end
    total += 4;
    if (moisture_sensor !== 1'b0) begin bad++; $display("FAIL reset_sensor: got %b want 0", moisture_sensor); end
    if (avg_data !== '0)          begin bad++; $display("FAIL reset_avg: got %0d want 0", avg_data); end
    if (avg_valid !== 1'b0)       begin bad++; $display("FAIL reset_valid: got %b want 0", avg_valid); end
    if (sensor_fault !== 1'b0)    begin bad++; $display("FAIL reset_fault: got %b want 0", sensor_fault); end
    adc_valid = 1'b0;
    rst       = 1'b1;
    model_reset();
    idle(1);
  endtask

  task automatic test_dry();
    send(200);
    send(200);
    idle(3);
    send(200);
    idle(1);
    send(204);
    total += 3;
    if (avg_data !== DATA_W'(201)) begin bad++; $display("FAIL dry_avg: got %0d want 201", avg_data); end
    if (avg_valid !== 1'b1)        begin bad++; $display("FAIL dry_valid: got %b want 1", avg_valid); end
    if (moisture_sensor !== 1'b1)  begin bad++; $display("FAIL dry_sensor: got %b want 1", moisture_sensor); end
    idle(1);
  endtask

  task automatic test_hysteresis();
    block(400);
    total++;
    if (moisture_sensor !== 1'b1) begin bad++; $display("FAIL hyst_400_hold_dry: got %b want 1", moisture_sensor); end
    block(520);
    total++;
    if (moisture_sensor !== 1'b0) begin bad++; $display("FAIL hyst_520_wet: got %b want 0", moisture_sensor); end
    block(400);
    total++;
    if (moisture_sensor !== 1'b0) begin bad++; $display("FAIL hyst_400_hold_wet: got %b want 0", moisture_sensor); end
    block(299);
    total++;
    if (moisture_sensor !== 1'b1) begin bad++; $display("FAIL hyst_299_dry: got %b want 1", moisture_sensor); end
  endtask

  task automatic test_width();
    block(1023);
    total++;
    if (avg_data !== DATA_W'(1023)) begin bad++; $display("FAIL width_max: got %0d want 1023", avg_data); end
    send(0);
    send(0);
    send(0);
    send(3);
    total++;
    if (avg_data !== '0) begin bad++; $display("FAIL width_trunc: got %0d want 0", avg_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * N; i++) send(600);
    for (int i = 0; i < 2 * N; i++) send(250 + i);
    idle(1);
  endtask

  task automatic test_watchdog();
    send(100);
    send(100);
`ifdef MOIST_WATCHDOG_EN
    idle(TIMEOUT - 1);
    total++;
    if (sensor_fault !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0", sensor_fault); end
    idle(1);
    total += 2;
    if (sensor_fault !== 1'b1)    begin bad++; $display("FAIL wd_fault: got %b want 1", sensor_fault); end
    if (moisture_sensor !== 1'b0) begin bad++; $display("FAIL wd_force_wet: got %b want 0", moisture_sensor); end
    idle(3);
    total++;
    if (sensor_fault !== 1'b1) begin bad++; $display("FAIL wd_hold: got %b want 1", sensor_fault); end
    send(100);
    total++;
    if (sensor_fault !== 1'b0) begin bad++; $display("FAIL wd_clear: got %b want 0", sensor_fault); end
    send(100);
    send(100);
    send(100);
`else
    idle(TIMEOUT + 4);
    total += 2;
    if (sensor_fault !== 1'b0)    begin bad++; $display("FAIL wd_off_fault: got %b want 0", sensor_fault); end
    if (moisture_sensor !== 1'b1) begin bad++; $display("FAIL wd_off_hold: got %b want 1", moisture_sensor); end
    send(100);
    send(100);
`endif
    total++;
    if (avg_data !== DATA_W'(100)) begin bad++; $display("FAIL wd_block: got %0d want 100", avg_data); end
  endtask

  task automatic test_reset_mid();
    send(900);
    send(900);
    send(900);
    rst = 1'b0;
    #1;
    total++;
    if (moisture_sensor !== 1'b0) begin bad++; $display("FAIL rmid_async: got %b want 0", moisture_sensor); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    block(100);
    total += 2;
    if (avg_data !== DATA_W'(100)) begin bad++; $display("FAIL rmid_avg: got %0d want 100", avg_data); end
    if (moisture_sensor !== 1'b1)  begin bad++; $display("FAIL rmid_sensor: got %b want 1", moisture_sensor); end
  endtask

  initial begin
    test_reset();
    test_dry();
    test_hysteresis();
    test_width();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    idle(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
